quad_encoder_emulator: RTL and testbench
========================================

# quad_encoder_emulator

Synthetic incremental-encoder source for the line-scan camera path. Generates quadrature A/B plus an index (Z) channel at a programmed step rate and direction, with a signed position count and an optional step limit. Drives the same encoder inputs that a physical rotary encoder drives on the line-scan trigger input, so the line trigger chain can be exercised on the bench and in self-test without moving mechanics.

## Interface
Parameters:
- CNT_W, 32, width of stepPeriod and of the internal period counter
- POS_W, 32, width of position (two's complement)

Ports:
- fclk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  single-cycle pulse: begin a run
- stop  in  1  single-cycle pulse: abort a run
- dir  in  1  0 = forward (A leads B), 1 = reverse (B leads A)
- stepPeriod  in  CNT_W  fclk cycles per quadrature state; values 0 and 1 are treated as 2
- stepLimit  in  32  quadrature steps per run; 0 = free-run until stop
- countsPerRev  in  16  steps per index period; 0 = index disabled
- posClr  in  1  single-cycle pulse: clear position and index phase
- quadA  out  1  channel A
- quadB  out  1  channel B
- quadZ  out  1  index channel
- position  out  POS_W  signed step count
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse when stepLimit reached

## Operation
- FSM states: IDLE, RUN.
  - IDLE -> RUN on start (and not stop).
  - RUN -> IDLE on stop, or on the step that makes stepsDone == stepLimit (stepLimit != 0).
  - start in RUN is ignored; stop in IDLE is ignored; start and stop in the same cycle: stop wins, stay/go IDLE.
- Start load: period counter <- 0, stepsDone <- 0. stepLimit is latched at start. Quad phase and position are not reset by start.
- Period counter increments each RUN cycle. When it equals effective period - 1, a step tick fires and the counter returns to 0.
  - stepPeriod is re-sampled at every tick.
  - dir is sampled only at the tick.
- Quad phase sequence (A,B):
  - forward 00 -> 10 -> 11 -> 01 -> 00
  - reverse 00 -> 01 -> 11 -> 10 -> 00
  - Direction reversal mid-run continues from the current phase with no skipped or repeated state.
- position: +1 per forward step, -1 per reverse step; wraps modulo 2^POS_W.
- Index phase revCnt counts 0..countsPerRev-1: increments on a forward step, decrements on a reverse step, wrapping in both directions.
- quadZ = (countsPerRev != 0) && (revCnt == 0); it lasts one full quad state.
- posClr: position <- 0 and revCnt <- 0. If it coincides with a step, the clear wins for position and revCnt, and the quad outputs still advance.
- stop: quad outputs hold their current levels (no return to 00). done is not asserted on stop.
- rst (any state, mid-run included): state IDLE, quadA = quadB = 0, quadZ = 0 (revCnt 0 but Z gated low in IDLE until the first step), position 0, busy 0, done 0, counters 0.

## Timing
- All outputs are registered.
- start sampled at edge 0 -> busy high after edge 0. The first quad transition is visible after edge P (P = effective period), then one transition every P cycles. A and B each have period 4P.
- A step tick updates quadA/quadB, position and quadZ at the same edge.
- Limit reached: at the tick edge, busy falls and done is high for exactly the following cycle.
- A dir change applied k cycles before a tick takes effect at that tick. A stepPeriod change takes effect from the next interval.
- Loopback into the Triggen encoder input needs stepPeriod >= 64, because its 50-cycle input debounce must see each level stable.

## Structure
- Package quad_enc_pkg holds:
  - FSM state enum (IDLE, RUN)
  - forward and reverse 2-bit phase tables
  - MIN_PERIOD = 2
- Sub-module quad_step_timer: period counter with min-clamp, producing a one-cycle tick. Clear on start; enable = RUN.
- The top level holds the FSM, phase register, position, revCnt, stepsDone and the done pulse.

## Test plan
- Reset mid-run: run, assert rst for 1 cycle -> next cycle A=B=Z=0, position=0, busy=0. The following start resumes at phase 00.
- Forward: stepPeriod=4, stepLimit=8, dir=0, start -> first edge 4 cycles after start; (A,B) = 10,11,01,00,10,11,01,00; position=8; done pulse 1 cycle after the 8th step; busy low.
- Reverse + clamp: stepPeriod=1 (runs as 2), dir=1, stepLimit=4 -> (A,B) = 01,11,10,00 at 2-cycle spacing; position=-4 (0xFFFFFFFC).
- Index: countsPerRev=4, forward free-run, stepPeriod=3 -> quadZ high for 3 cycles once every 12 cycles. Reverse at the next tick -> Z reappears with decrementing revCnt. countsPerRev=0 -> Z stays 0.
- Control collisions:
  - start+stop in the same cycle -> stays IDLE.
  - stop mid-run with A=1,B=1 -> outputs hold 11; no done pulse.
  - posClr coincident with a step -> position=0, phase still advances.
- Loopback: stepPeriod=100 into Triggen -> its measured A-high width is 200 cycles (±debounce delay) and it produces a steady pulseOut.

Source files
------------

// File: rtl/quad_enc_pkg.sv
// Shared types and constants for the quadrature encoder emulator.
// Phase tables are indexed by the current {A,B} code and yield the next code.
package quad_enc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Entry {A,B}=ab lives at bits [2*ab +: 2].
  // Forward: 00->10->11->01->00.
  // Reverse: 00->01->11->10->00.
  localparam logic [7:0] FWD_TABLE = {2'b01, 2'b11, 2'b00, 2'b10};
  localparam logic [7:0] REV_TABLE = {2'b10, 2'b00, 2'b11, 2'b01};

  localparam int MIN_PERIOD = 2;

  function automatic logic [1:0] next_phase(input logic [1:0] ab, input logic reverse);
    logic [7:0] tbl;
    tbl = reverse ? REV_TABLE : FWD_TABLE;
    return tbl[{ab, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/quad_encoder_emulator_timer.sv
// quad_step_timer: free-running interval counter that emits a one-cycle tick
// every effective period. The period is latched at clear and again at each tick.
module quad_step_timer
  import quad_enc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             fclk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] step_period,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;

  function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] p);
    return (p < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : p;
  endfunction

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    tick     = 1'b0;
    if (clear) begin
      cnt_d    = '0;
      period_d = clamp_period(step_period);
    end else if (enable) begin
      if (cnt_q == period_q - CNT_W'(1)) begin
        tick     = 1'b1;
        cnt_d    = '0;
        period_d = clamp_period(step_period);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge fclk) begin
    if (rst) begin
      cnt_q    <= '0;
      period_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
    end
  end

endmodule

// File: rtl/quad_encoder_emulator.sv
// Synthetic incremental encoder: quadrature A/B plus index Z at a programmed
// step rate and direction, with signed position and an optional step limit.
module quad_encoder_emulator
  import quad_enc_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int POS_W = 32
) (
  input  logic             fclk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic [CNT_W-1:0] stepPeriod,
  input  logic [31:0]      stepLimit,
  input  logic [15:0]      countsPerRev,
  input  logic             posClr,
  output logic             quadA,
  output logic             quadB,
  output logic             quadZ,
  output logic [POS_W-1:0] position,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [15:0]      rev_q, rev_d;
  logic             z_q, z_d;
  logic             done_q, done_d;
  logic [31:0]      steps_q, steps_d;
  logic [31:0]      limit_q, limit_d;

  logic start_go;
  logic step;
  logic tick;

  // Stop beats start when both arrive in IDLE.
  assign start_go = (state_q == IDLE) && start && !stop;
  assign step     = (state_q == RUN) && tick && !stop;

  quad_step_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .fclk       (fclk),
    .rst        (rst),
    .clear      (start_go),
    .enable     (state_q == RUN),
    .step_period(stepPeriod),
    .tick       (tick)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pos_d   = pos_q;
    rev_d   = rev_q;
    z_d     = z_q;
    done_d  = 1'b0;
    steps_d = steps_q;
    limit_d = limit_q;

    case (state_q)
      IDLE: begin
        if (start_go) begin
          state_d = RUN;
          steps_d = '0;
          limit_d = stepLimit;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (step) begin
          phase_d = next_phase(phase_q, dir);
          steps_d = steps_q + 32'd1;
          if (!dir) begin
            pos_d = pos_q + POS_W'(1);
            if (countsPerRev == '0)
              rev_d = '0;
            else
              rev_d = (rev_q >= countsPerRev - 16'd1) ? '0 : rev_q + 16'd1;
          end else begin
            pos_d = pos_q - POS_W'(1);
            if (countsPerRev == '0)
              rev_d = '0;
            else
              rev_d = (rev_q == '0 || rev_q >= countsPerRev) ? countsPerRev - 16'd1
                                                             : rev_q - 16'd1;
          end
          if (limit_q != '0 && steps_d == limit_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear overrides a coincident step for position and index phase only.
    if (posClr) begin
      pos_d = '0;
      rev_d = '0;
    end

    // Z is refreshed only on a step so it spans one whole quadrature state.
    if (step)
      z_d = (countsPerRev != '0) && (rev_d == '0);
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= 2'b00;
      pos_q   <= '0;
      rev_q   <= '0;
      z_q     <= 1'b0;
      done_q  <= 1'b0;
      steps_q <= '0;
      limit_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pos_q   <= pos_d;
      rev_q   <= rev_d;
      z_q     <= z_d;
      done_q  <= done_d;
      steps_q <= steps_d;
      limit_q <= limit_d;
    end
  end

  assign quadA    = phase_q[1];
  assign quadB    = phase_q[0];
  assign quadZ    = z_q;
  assign position = pos_q;
  assign busy     = (state_q == RUN);
  assign done     = done_q;

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Self-checking bench: directed scenarios with literal expectations, then a
// randomized run, all compared every cycle against a behavioural model.
module tb_quad_encoder_emulator;

  localparam int CNT_W = 32;
  localparam int POS_W = 32;

  logic             fclk = 1'b0;
  logic             rst, start, stop, dir, posClr;
  logic [CNT_W-1:0] stepPeriod;
  logic [31:0]      stepLimit;
  logic [15:0]      countsPerRev;
  logic             quadA, quadB, quadZ, busy, done;
  logic [POS_W-1:0] position;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Model state: quad state as an index into the forward Gray sequence.
  logic [1:0]  seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  bit          m_busy, m_done, m_z;
  int          m_idx, m_cnt, m_per, m_rev;
  logic [31:0] m_pos, m_steps, m_limit;

  logic [1:0] fwd_lit [8] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] rev_lit [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  quad_encoder_emulator #(
    .CNT_W(CNT_W),
    .POS_W(POS_W)
  ) dut (
    .fclk        (fclk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .dir         (dir),
    .stepPeriod  (stepPeriod),
    .stepLimit   (stepLimit),
    .countsPerRev(countsPerRev),
    .posClr      (posClr),
    .quadA       (quadA),
    .quadB       (quadB),
    .quadZ       (quadZ),
    .position    (position),
    .busy        (busy),
    .done        (done)
  );

  always #5 fclk = ~fclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic int eff_period(input logic [31:0] p);
    return (p < 32'd2) ? 2 : int'(p);
  endfunction

  // Behavioural model: one step every P cycles of RUN, Gray index +/-1 mod 4.
  always @(posedge fclk) begin
    bit stepped;
    int cpr;
    stepped = 1'b0;
    cpr     = int'(countsPerRev);
    if (rst) begin
      m_busy = 0; m_done = 0; m_z = 0; m_idx = 0; m_cnt = 0; m_per = 2;
      m_rev = 0; m_pos = '0; m_steps = '0; m_limit = '0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (start && !stop) begin
          m_busy = 1; m_cnt = 0; m_steps = '0; m_limit = stepLimit;
          m_per = eff_period(stepPeriod);
        end
      end else if (stop) begin
        m_busy = 0;
      end else begin
        m_cnt++;
        if (m_cnt == m_per) begin
          m_cnt   = 0;
          m_per   = eff_period(stepPeriod);
          stepped = 1'b1;
          if (!dir) begin
            m_idx = (m_idx + 1) % 4;
            m_pos = m_pos + 32'd1;
            m_rev = (cpr == 0) ? 0 : (m_rev + 1) % cpr;
          end else begin
            m_idx = (m_idx + 3) % 4;
            m_pos = m_pos - 32'd1;
            m_rev = (cpr == 0) ? 0 : (m_rev + cpr - 1) % cpr;
          end
          m_steps = m_steps + 32'd1;
          if (m_limit != 0 && m_steps == m_limit) begin
            m_busy = 0;
            m_done = 1;
          end
        end
      end
      if (posClr) begin
        m_pos = '0;
        m_rev = 0;
      end
      if (stepped) m_z = (cpr != 0) && (m_rev == 0);
    end
  end

  always @(negedge fclk) begin
    if (cmp_en)
      check("cycle", {27'd0, quadA, quadB, quadZ, busy, done, position},
                     {27'd0, seq[m_idx], m_z, m_busy, m_done, m_pos});
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge fclk);
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cyc(1); stop = 1'b0;
  endtask

  task automatic pulse_posclr();
    posClr = 1'b1; cyc(1); posClr = 1'b0;
  endtask

  initial begin
    int zc;
    bit done_seen;

    rst = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0; posClr = 1'b0;
    stepPeriod = 4; stepLimit = 0; countsPerRev = 0;
    cyc(2);
    rst = 1'b0;
    cmp_en = 1'b1;
    check("reset_state", {27'd0, quadA, quadB, quadZ, busy, done, position}, 64'd0);

    // Forward, period 4, limit 8.
    stepPeriod = 4; stepLimit = 8; dir = 1'b0;
    pulse_start();
    check("busy_after_start", busy, 1);
    cyc(3);
    check("fwd_before_first", {quadA, quadB}, 2'b00);
    cyc(1);
    check("fwd_ab", {quadA, quadB}, fwd_lit[0]);
    for (int k = 1; k < 8; k++) begin
      cyc(4);
      check("fwd_ab", {quadA, quadB}, fwd_lit[k]);
    end
    check("fwd_position", position, 64'd8);
    check("fwd_done", done, 1);
    check("fwd_busy_low", busy, 0);
    cyc(1);
    check("fwd_done_one_cycle", done, 0);

    // Reverse with clamped period.
    pulse_posclr();
    check("posclr_idle", position, 64'd0);
    stepPeriod = 1; stepLimit = 4; dir = 1'b1;
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      cyc(2);
      check("rev_ab", {quadA, quadB}, rev_lit[k]);
    end
    check("rev_position", position, 64'hFFFF_FFFC);
    check("rev_done", done, 1);

    // Index: 4 counts per rev, period 3, forward free-run then reverse.
    countsPerRev = 4; stepPeriod = 3; stepLimit = 0; dir = 1'b0;
    pulse_posclr();
    pulse_start();
    cyc(2);
    zc = 0;
    for (int k = 0; k < 24; k++) begin
      cyc(1);
      zc += int'(quadZ);
    end
    check("z_high_cycles", zc, 6);
    dir = 1'b1;
    cyc(9);
    check("z_rev_before", quadZ, 0);
    cyc(1);
    check("z_rev_again", quadZ, 1);
    pulse_stop();

    // Index disabled.
    countsPerRev = 0;
    pulse_start();
    cyc(3);
    zc = 0;
    for (int k = 0; k < 15; k++) begin
      cyc(1);
      zc += int'(quadZ);
    end
    check("z_disabled", zc, 0);
    pulse_stop();

    // start and stop together in IDLE.
    start = 1'b1; stop = 1'b1;
    cyc(1);
    start = 1'b0; stop = 1'b0;
    check("start_stop_idle", busy, 0);

    // Stop mid-run while at 11 holds the outputs and gives no done.
    rst = 1'b1; cyc(1); rst = 1'b0;
    stepPeriod = 4; dir = 1'b0; stepLimit = 0;
    pulse_start();
    cyc(8);
    check("hold_pre_ab", {quadA, quadB}, 2'b11);
    pulse_stop();
    done_seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      done_seen |= done;
    end
    check("hold_ab", {quadA, quadB}, 2'b11);
    check("hold_busy", busy, 0);
    check("hold_no_done", done_seen, 0);

    // posClr on the same edge as a step.
    pulse_start();
    cyc(3);
    posClr = 1'b1;
    cyc(1);
    posClr = 1'b0;
    check("posclr_step_pos", position, 64'd0);
    check("posclr_step_ab", {quadA, quadB}, 2'b01);
    pulse_stop();

    // Reset mid-run, then restart from phase 00.
    stepPeriod = 2;
    pulse_start();
    cyc(5);
    rst = 1'b1; cyc(1); rst = 1'b0;
    check("midrun_reset", {27'd0, quadA, quadB, quadZ, busy, done, position}, 64'd0);
    pulse_start();
    cyc(2);
    check("restart_ab", {quadA, quadB}, 2'b10);
    pulse_stop();

    // Randomized traffic; stop is kept off tick edges.
    for (int i = 0; i < 4000; i++) begin
      @(negedge fclk);
      start = ($urandom_range(0, 9) == 0);
      stop  = ($urandom_range(0, 39) == 0) && !(m_busy && (m_cnt + 1 == m_per));
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      if ($urandom_range(0, 7) == 0) stepPeriod = $urandom_range(0, 6);
      stepLimit = $urandom_range(0, 12);
      posClr = ($urandom_range(0, 29) == 0);
      if (posClr && $urandom_range(0, 2) == 0) countsPerRev = 16'($urandom_range(0, 5));
      rst = ($urandom_range(0, 499) == 0);
    end
    start = 1'b0; stop = 1'b0; posClr = 1'b0; rst = 1'b0;
    cyc(2);
    cmp_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
